// File: rtl/vnu_iter_sched_pkg.sv
// Shared decoder-control types and default constants for the VNU iteration scheduler.
package vnu_iter_sched_pkg;

    localparam int unsigned DefMaxIter  = 10;
    localparam int unsigned DefIterW    = 4;
    localparam int unsigned DefRdCycles = 8;
    localparam int unsigned DefRdAddrW  = 3;
    localparam int unsigned DefWrTimeout = 64;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StInitLoad = 3'd1,
        StRead     = 3'd2,
        StWaitWr   = 3'd3,
        StCheck    = 3'd4,
        StDone     = 3'd5
    } vnu_state_e;

endpackage

// File: rtl/vnu_wr_watchdog.sv
// Loadable down-counter guarding the write-back wait; expiry flags a zero count.
module vnu_wr_watchdog #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/vnu_iter_sched.sv
// VNU iteration scheduler: init load, per-iteration LUT reads, write-back wait and
// syndrome check, with all outputs registered.
module vnu_iter_sched
    import vnu_iter_sched_pkg::*;
#(
    parameter int unsigned MAX_ITER   = DefMaxIter,
    parameter int unsigned ITER_W     = DefIterW,
    parameter int unsigned RD_CYCLES  = DefRdCycles,
    parameter int unsigned RD_ADDR_W  = DefRdAddrW,
    parameter int unsigned WR_TIMEOUT = DefWrTimeout
) (
    input  logic                 read_clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 vnu_wr_i,
    input  logic                 syndrome_valid_i,
    input  logic                 syndrome_pass_i,
    output logic                 vnu_init_load_en_o,
    output logic                 vnu_rd_finish_o,
    output logic                 vnu_rd_en_o,
    output logic [RD_ADDR_W-1:0] vnu_rd_addr_o,
    output logic                 iter_update_o,
    output logic [ITER_W-1:0]    iter_cnt_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 success_o,
    output logic                 err_o
);

    localparam int unsigned          WdW      = $clog2(WR_TIMEOUT);
    localparam logic [RD_ADDR_W-1:0] LastAddr = RD_ADDR_W'(RD_CYCLES - 1);
    localparam logic [ITER_W-1:0]    LastIter = ITER_W'(MAX_ITER - 1);
    localparam logic [WdW-1:0]       WdLoad   = WdW'(WR_TIMEOUT - 1);

    vnu_state_e           r_state, w_state_nxt;
    logic [RD_ADDR_W-1:0] r_rd_addr, w_addr_nxt;
    logic [ITER_W-1:0]    r_iter_cnt, w_iter_nxt;
    logic                 r_iter_update, w_upd_nxt;
    logic                 r_success, w_succ_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_rd_en, w_rd_en_nxt;
    logic                 r_init_load, w_init_nxt;
    logic                 r_rd_finish, w_fin_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_wd_expired;

    // Watchdog reloads outside WAIT_WR so it holds WR_TIMEOUT-1 on the entry cycle.
    vnu_wr_watchdog #(
        .CNT_W (WdW)
    ) u_wr_watchdog (
        .i_clk      (read_clk),
        .i_rst_n    (rstn),
        .i_clr      (abort_i),
        .i_load     (r_state != StWaitWr),
        .i_en       (r_state == StWaitWr),
        .i_load_val (WdLoad),
        .o_expired  (w_wd_expired)
    );

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= StIdle;
            r_rd_addr     <= '0;
            r_iter_cnt    <= '0;
            r_iter_update <= 1'b0;
            r_success     <= 1'b0;
            r_err         <= 1'b0;
            r_rd_en       <= 1'b0;
            r_init_load   <= 1'b0;
            r_rd_finish   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rd_addr     <= w_addr_nxt;
            r_iter_cnt    <= w_iter_nxt;
            r_iter_update <= w_upd_nxt;
            r_success     <= w_succ_nxt;
            r_err         <= w_err_nxt;
            r_rd_en       <= w_rd_en_nxt;
            r_init_load   <= w_init_nxt;
            r_rd_finish   <= w_fin_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_rd_addr;
        w_iter_nxt  = r_iter_cnt;
        w_upd_nxt   = r_iter_update;
        w_succ_nxt  = r_success;
        w_err_nxt   = r_err;
        if (abort_i) begin
            w_state_nxt = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (start_i) begin
                        w_state_nxt = StInitLoad;
                        w_addr_nxt  = '0;
                        w_iter_nxt  = '0;
                        w_upd_nxt   = 1'b0;
                        w_succ_nxt  = 1'b0;
                        w_err_nxt   = 1'b0;
                    end
                end
                StInitLoad, StRead: begin
                    if (r_rd_addr == LastAddr) begin
                        w_state_nxt = StWaitWr;
                    end else begin
                        w_addr_nxt = r_rd_addr + 1'b1;
                    end
                end
                StWaitWr: begin
                    if (vnu_wr_i) begin
                        w_state_nxt = StCheck;
                    end else if (w_wd_expired) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = StDone;
                    end
                end
                StCheck: begin
                    if (syndrome_valid_i) begin
                        if (syndrome_pass_i) begin
                            w_succ_nxt  = 1'b1;
                            w_state_nxt = StDone;
                        end else if (r_iter_cnt == LastIter) begin
                            w_state_nxt = StDone;
                        end else begin
                            w_iter_nxt  = r_iter_cnt + 1'b1;
                            w_upd_nxt   = ~r_iter_update;
                            w_addr_nxt  = '0;
                            w_state_nxt = StRead;
                        end
                    end
                end
                StDone:  w_state_nxt = StIdle;
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // Registered outputs are decoded from the next state so they line up with it.
    always_comb begin
        w_rd_en_nxt = (w_state_nxt == StInitLoad) || (w_state_nxt == StRead);
        w_init_nxt  = (w_state_nxt == StInitLoad);
        w_fin_nxt   = w_rd_en_nxt && (w_addr_nxt == LastAddr);
        w_busy_nxt  = (w_state_nxt != StIdle);
        w_done_nxt  = (w_state_nxt == StDone);
    end

    assign vnu_init_load_en_o = r_init_load;
    assign vnu_rd_finish_o    = r_rd_finish;
    assign vnu_rd_en_o        = r_rd_en;
    assign vnu_rd_addr_o      = r_rd_addr;
    assign iter_update_o      = r_iter_update;
    assign iter_cnt_o         = r_iter_cnt;
    assign busy_o             = r_busy;
    assign done_o             = r_done;
    assign success_o          = r_success;
    assign err_o              = r_err;

endmodule

// File: tb/tb_vnu_iter_sched.sv
// Scoreboard bench for vnu_iter_sched: a timeline model queues expected read/done
// events with their cycle stamps, and a monitor pops and compares them.
module tb_vnu_iter_sched;

    localparam int MAX_ITER   = 10;
    localparam int ITER_W     = 4;
    localparam int RD_CYCLES  = 8;
    localparam int RD_ADDR_W  = 3;
    localparam int WR_TIMEOUT = 64;

    typedef struct packed {
        int unsigned cyc;
        logic        is_done;
        logic [2:0]  addr;
        logic        init;
        logic        fin;
        logic [3:0]  iter;
        logic        upd;
        logic        succ;
        logic        err;
    } exp_t;

    logic                 read_clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 start_i = 1'b0;
    logic                 abort_i = 1'b0;
    logic                 vnu_wr_i = 1'b0;
    logic                 syndrome_valid_i = 1'b0;
    logic                 syndrome_pass_i = 1'b0;
    logic                 vnu_init_load_en_o;
    logic                 vnu_rd_finish_o;
    logic                 vnu_rd_en_o;
    logic [RD_ADDR_W-1:0] vnu_rd_addr_o;
    logic                 iter_update_o;
    logic [ITER_W-1:0]    iter_cnt_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 success_o;
    logic                 err_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    logic m_succ = 1'b0;
    logic m_err = 1'b0;

    vnu_iter_sched #(
        .MAX_ITER   (MAX_ITER),
        .ITER_W     (ITER_W),
        .RD_CYCLES  (RD_CYCLES),
        .RD_ADDR_W  (RD_ADDR_W),
        .WR_TIMEOUT (WR_TIMEOUT)
    ) dut (
        .read_clk           (read_clk),
        .rstn               (rstn),
        .start_i            (start_i),
        .abort_i            (abort_i),
        .vnu_wr_i           (vnu_wr_i),
        .syndrome_valid_i   (syndrome_valid_i),
        .syndrome_pass_i    (syndrome_pass_i),
        .vnu_init_load_en_o (vnu_init_load_en_o),
        .vnu_rd_finish_o    (vnu_rd_finish_o),
        .vnu_rd_en_o        (vnu_rd_en_o),
        .vnu_rd_addr_o      (vnu_rd_addr_o),
        .iter_update_o      (iter_update_o),
        .iter_cnt_o         (iter_cnt_o),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .success_o          (success_o),
        .err_o              (err_o)
    );

    always #5 read_clk = ~read_clk;
    always @(posedge read_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge read_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [14:0] all_outs();
        return {vnu_init_load_en_o, vnu_rd_finish_o, vnu_rd_en_o, vnu_rd_addr_o, iter_update_o,
                iter_cnt_o, busy_o, done_o, success_o, err_o};
    endfunction

    // Reads of iteration k appear on cycles t+1 .. t+RD_CYCLES.
    task automatic push_window(input int t, input int k, input int lim);
        exp_t e;
        for (int a = 0; a < RD_CYCLES; a++) begin
            if (lim >= 0 && a > lim) break;
            e = '0;
            e.cyc  = t + 1 + a;
            e.addr = 3'(a);
            e.init = (k == 0);
            e.fin  = (a == RD_CYCLES - 1);
            e.iter = 4'(k);
            e.upd  = ((k % 2) == 1);
            q.push_back(e);
        end
    endtask

    task automatic push_done(input int t, input int k, input logic succ, input logic err);
        exp_t e;
        e = '0;
        e.cyc     = t;
        e.is_done = 1'b1;
        e.iter    = 4'(k);
        e.upd     = ((k % 2) == 1);
        e.succ    = succ;
        e.err     = err;
        q.push_back(e);
    endtask

    task automatic finish_run();
        chk("done_cycle_busy", busy_o, 1);
        chk("done_cycle_flags", {success_o, err_o}, {m_succ, m_err});
        tick();
        chk("idle_after_done_busy", busy_o, 0);
        chk("idle_flags_held", {success_o, err_o}, {m_succ, m_err});
        tick();
    endtask

    task automatic do_run(input int pass_at, input int tmo_at, input int wr_fix,
                          input int abort_addr, input bit rst_in_chk);
        int t, w, c, s;
        t = cyc;
        start_i = 1'b1;
        m_succ = 1'b0;
        m_err = 1'b0;
        push_window(t, 0, abort_addr);
        tick();
        start_i = 1'b0;
        for (int k = 0; k < MAX_ITER; k++) begin
            for (int a = 0; a < RD_CYCLES; a++) begin
                if (k == 0 && a == abort_addr) begin
                    start_i = 1'b0;
                    syndrome_valid_i = 1'b0;
                    abort_i = 1'b1;
                    tick();
                    abort_i = 1'b0;
                    chk("abort_rd_en", vnu_rd_en_o, 0);
                    chk("abort_busy", busy_o, 0);
                    chk("abort_flags", {success_o, err_o}, {m_succ, m_err});
                    tick();
                    return;
                end
                // Stray start and syndrome strobes during a read window must be ignored.
                start_i = 1'($urandom_range(0, 1));
                syndrome_valid_i = 1'($urandom_range(0, 1));
                syndrome_pass_i = 1'($urandom_range(0, 1));
                tick();
            end
            start_i = 1'b0;
            syndrome_valid_i = 1'b0;
            syndrome_pass_i = 1'b0;
            w = cyc;
            if (k == tmo_at) begin
                push_done(w + WR_TIMEOUT, k, 1'b0, 1'b1);
                m_err = 1'b1;
                repeat (WR_TIMEOUT) tick();
                finish_run();
                return;
            end
            c = (wr_fix >= 0) ? wr_fix : int'($urandom_range(0, 12));
            repeat (c) tick();
            vnu_wr_i = 1'b1;
            tick();
            vnu_wr_i = 1'b0;
            if (rst_in_chk) begin
                repeat ($urandom_range(0, 2)) tick();
                #2 rstn = 1'b0;
                #1;
                chk("async_reset_outputs", 64'(all_outs()), 0);
                tick();
                tick();
                rstn = 1'b1;
                m_succ = 1'b0;
                m_err = 1'b0;
                tick();
                return;
            end
            s = $urandom_range(0, 3);
            repeat (s) tick();
            t = cyc;
            syndrome_valid_i = 1'b1;
            syndrome_pass_i = (k == pass_at);
            if (k == pass_at || k == MAX_ITER - 1) begin
                m_succ = (k == pass_at);
                push_done(t + 1, k, m_succ, 1'b0);
                tick();
                syndrome_valid_i = 1'b0;
                syndrome_pass_i = 1'b0;
                finish_run();
                return;
            end
            push_window(t, k + 1, -1);
            tick();
            syndrome_valid_i = 1'b0;
            syndrome_pass_i = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        fork
            forever begin
                @(negedge read_clk);
                if (rstn && (vnu_rd_en_o || done_o)) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: rd_en=%0b done=%0b addr=%0d at cycle %0d",
                                 vnu_rd_en_o, done_o, vnu_rd_addr_o, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("event_cycle", 64'(cyc), 64'(e.cyc));
                        chk("event_content",
                            {done_o, (done_o ? 3'b0 : vnu_rd_addr_o), vnu_init_load_en_o,
                             vnu_rd_finish_o, iter_cnt_o, iter_update_o, success_o, err_o},
                            {e.is_done, (e.is_done ? 3'b0 : e.addr), e.init, e.fin, e.iter,
                             e.upd, e.succ, e.err});
                    end
                end
            end
        join_none

        #1;
        chk("reset_outputs", 64'(all_outs()), 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("idle_after_reset", 64'(all_outs()), 0);

        do_run(0, -1, 1, -1, 1'b0);          // converge on first iteration
        do_run(-1, -1, -1, -1, 1'b0);        // exhaust all iterations
        do_run(-1, 0, -1, -1, 1'b0);         // write-back timeout
        do_run(0, -1, WR_TIMEOUT - 1, -1, 1'b0); // write arrives on the last watchdog cycle
        do_run(1, -1, -1, 3, 1'b0);          // abort at read address 3
        do_run(2, -1, -1, -1, 1'b0);         // restarts cleanly after abort
        do_run(-1, -1, -1, -1, 1'b1);        // async reset in CHECK
        do_run(1, -1, -1, -1, 1'b0);

        start_i = 1'b1;
        abort_i = 1'b1;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("start_abort_idle_busy", busy_o, 0);
        chk("start_abort_idle_rd_en", vnu_rd_en_o, 0);
        tick();

        for (int r = 0; r < 6; r++) begin
            do_run(int'($urandom_range(0, MAX_ITER)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                   -1, -1, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end

        repeat (4) tick();
        chk("queue_drained", 64'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vnu_iter_sched.md
# vnu_iter_sched

Iteration scheduler for the IB-LUT LDPC decoder's variable-node unit (VNU). It sequences each decoding run through initial load, per-iteration LUT reads, the write-back handshake and the syndrome check. It drives the load-enable, read-finish and iteration-update controls of the VNU write-update handshake logic and generates the read address for the decomposed 2-input LUT stages. It sits between the top-level decode start/stop interface and the VNU datapath, all on the read clock domain.

## Interface
- `MAX_ITER`, 10, maximum decoding iterations per run (≥1)
- `ITER_W`, 4, width of iteration counter; 2^ITER_W ≥ MAX_ITER
- `RD_CYCLES`, 8, LUT read cycles per iteration (≥2)
- `RD_ADDR_W`, 3, read address width; 2^RD_ADDR_W ≥ RD_CYCLES
- `WR_TIMEOUT`, 64, max cycles waiting for write-back before error (≥2)

- `read_clk` in 1 — sole clock, all logic on rising edge
- `rstn` in 1 — asynchronous, active-low reset
- `start_i` in 1 — start a decoding run (sampled in IDLE only)
- `abort_i` in 1 — synchronous abort, any state
- `vnu_wr_i` in 1 — VNU write-enable level from the write-update handshake
- `syndrome_valid_i` in 1 — syndrome result valid strobe
- `syndrome_pass_i` in 1 — all parity checks satisfied (qualified by valid)
- `vnu_init_load_en_o` out 1 — initial-load phase enable
- `vnu_rd_finish_o` out 1 — one-cycle pulse on the last LUT read of an iteration
- `vnu_rd_en_o` out 1 — LUT read enable
- `vnu_rd_addr_o` out RD_ADDR_W — LUT read address
- `iter_update_o` out 1 — iteration phase level, inverted once per new iteration
- `iter_cnt_o` out ITER_W — current iteration index, 0-based
- `busy_o` out 1 — high in every state except IDLE
- `done_o` out 1 — one-cycle completion pulse
- `success_o` out 1 — run converged; held until next accepted start
- `err_o` out 1 — write-back timeout; held until next accepted start

## Operation
- States: IDLE, INIT_LOAD, READ, WAIT_WR, CHECK, DONE.
- IDLE → INIT_LOAD on `start_i`:
  - clear iter_cnt, rd_addr, `success_o`, `err_o` and `iter_update_o`.
- INIT_LOAD:
  - `vnu_init_load_en_o`=1 and `vnu_rd_en_o`=1.
  - rd_addr increments each cycle from 0 to RD_CYCLES-1.
  - On the address RD_CYCLES-1 cycle, `vnu_rd_finish_o`=1; next state WAIT_WR.
- READ: same as INIT_LOAD, but with `vnu_init_load_en_o`=0.
- WAIT_WR:
  - Watchdog counts cycles from entry.
  - `vnu_wr_i`=1 → CHECK.
  - Watchdog reaches WR_TIMEOUT-1 with `vnu_wr_i` still 0 → set `err_o`, go to DONE.
  - If both happen in the same cycle, `vnu_wr_i` wins.
- CHECK: waits for `syndrome_valid_i`.
  - `syndrome_pass_i`=1 → set `success_o`, go to DONE.
  - Else, iter_cnt == MAX_ITER-1 → DONE with `success_o`=0.
  - Else: iter_cnt+1, invert `iter_update_o`, rd_addr←0, go to READ.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `abort_i` (any non-IDLE state) → IDLE next cycle:
  - no `done_o` pulse;
  - `success_o` and `err_o` unchanged;
  - `abort_i` takes priority over every other transition.
- `start_i` outside IDLE is ignored. `start_i` and `abort_i` together in IDLE → stay in IDLE.
- `syndrome_valid_i` outside CHECK is ignored.

## Timing
- All outputs registered. On reset, every output and the state register are 0 (state = IDLE).
- Start to first `vnu_rd_en_o`: 1 cycle.
- Read window: exactly RD_CYCLES consecutive cycles with contiguous addresses 0..RD_CYCLES-1; no gaps.
- `vnu_rd_finish_o` and the last read address appear in the same cycle.
- WAIT_WR → CHECK: 1 cycle after `vnu_wr_i` is sampled high.
- CHECK → READ: 1 cycle after the valid strobe. `iter_update_o` and `iter_cnt_o` change in the same cycle as the READ entry.
- `done_o` asserts 1 cycle after leaving CHECK or WAIT_WR. `busy_o` falls in the cycle after `done_o`.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0; no done pulse.

## Structure
- Shared decoder-control package holds:
  - the state enum (3-bit encoding: IDLE=0, INIT_LOAD=1, READ=2, WAIT_WR=3, CHECK=4, DONE=5);
  - default parameter constants.
- Sub-module `vnu_wr_watchdog`: loadable down-counter with clear, enable and expiry flag. Width is clog2(WR_TIMEOUT). It is instantiated once and used for the WAIT_WR timeout.

## Test plan
- Converge first iteration: defaults, start, `vnu_wr_i`=1 two cycles after finish, valid+pass → reads at addresses 0..7 with init_load=1, iter_cnt=0, `done_o` pulse, `success_o`=1, `iter_update_o`=0.
- Max iterations: pass held 0 on every check → 10 read windows (first with init_load), iter_update toggles 9 times, final iter_cnt=9, `done_o`=1, `success_o`=0.
- Timeout: `vnu_wr_i` held 0 → `err_o`=1 and `done_o` pulse 64 cycles after WAIT_WR entry. `vnu_wr_i` rising on cycle 63 → CHECK, `err_o`=0.
- Abort in READ at address 3 → IDLE next cycle, `rd_en`=0, no `done_o`. Next start restarts at iter_cnt=0, address 0.
- Async reset asserted in CHECK mid-run → all outputs 0 immediately. Run restarts cleanly after deassertion.
- Start pulses during busy and stray `syndrome_valid_i` in READ → no effect on sequence, counts or flags.
